// File: rtl/hyper_cordic_iter_if.sv
// hyper_cordic_iter_if: operand/result handshake bundle for the hyperbolic CORDIC iterator
interface hyper_cordic_iter_if #(parameter int DWIDTH = 16);
    logic                     iValid;
    logic                     iReady;
    logic signed [DWIDTH-1:0] iX;
    logic signed [DWIDTH-1:0] iY;
    logic signed [DWIDTH-1:0] iZ;
    logic                     oValid;
    logic                     oReady;
    logic signed [DWIDTH-1:0] oCosh;
    logic signed [DWIDTH-1:0] oSinh;
    modport master (output iValid, iX, iY, iZ, oReady, input iReady, oValid, oCosh, oSinh);
    modport slave  (input iValid, iX, iY, iZ, oReady, output iReady, oValid, oCosh, oSinh);
endinterface

// File: rtl/hyper_cordic_iter.sv
// hyper_cordic_iter: iterative hyperbolic CORDIC, one micro-rotation per cycle, Q2.13 data
module hyper_cordic_iter #(
    parameter int DWIDTH = 16,
    parameter int NSTEP  = 16
) (
    input  logic               clk,
    input  logic               rst,
    hyper_cordic_iter_if.slave bus
);
    localparam int SW = $clog2(NSTEP);
    localparam int ATANH [0:15] = '{0, 4500, 2092, 1029, 513, 256, 128, 64, 32, 16, 8, 4, 2, 1, 1, 0};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                   state;
    logic [SW-1:0]            step;
    logic [SW-1:0]            sh;
    logic signed [DWIDTH-1:0] x, y, z;
    logic signed [DWIDTH-1:0] xs, ys, tz;
    logic signed [DWIDTH-1:0] x_n, y_n, z_n;
    logic signed [DWIDTH-1:0] cosh_q, sinh_q;
    logic                     valid_q;

    assign bus.iReady = (state == IDLE);
    assign bus.oValid = valid_q;
    assign bus.oCosh  = cosh_q;
    assign bus.oSinh  = sinh_q;

    // one micro-rotation; shifts 4 and 13 are repeated for convergence, both updates use old x/y
    always_comb begin
        sh  = (step < SW'(4)) ? step + SW'(1) : (step < SW'(14)) ? step : step - SW'(1);
        xs  = x >>> sh;
        ys  = y >>> sh;
        tz  = DWIDTH'(ATANH[sh]);
        x_n = z[DWIDTH-1] ? x - ys : x + ys;
        y_n = z[DWIDTH-1] ? y - xs : y + xs;
        z_n = z[DWIDTH-1] ? z + tz : z - tz;
    end

    // control FSM with datapath and registered result; DONE spends one cycle publishing the result
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            step    <= '0;
            x       <= '0;
            y       <= '0;
            z       <= '0;
            cosh_q  <= '0;
            sinh_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.iValid) begin
                    x     <= bus.iX;
                    y     <= bus.iY;
                    z     <= bus.iZ;
                    step  <= '0;
                    state <= RUN;
                end
                RUN: begin
                    x    <= x_n;
                    y    <= y_n;
                    z    <= z_n;
                    step <= step + SW'(1);
                    if (step == SW'(NSTEP - 1)) state <= DONE;
                end
                DONE: if (!valid_q) begin
                    cosh_q  <= x;
                    sinh_q  <= y;
                    valid_q <= 1'b1;
                end else if (bus.oReady) begin
                    valid_q <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hyper_cordic_iter.sv
// tb_hyper_cordic_iter: randomized and directed checks of hyper_cordic_iter against a behavioural model
module tb_hyper_cordic_iter;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    hyper_cordic_iter_if #(.DWIDTH(16)) bus ();

    hyper_cordic_iter #(.DWIDTH(16), .NSTEP(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int w16(input int v);
        logic [15:0] t;
        t = v[15:0];
        return int'($signed(t));
    endfunction

    function automatic void model(input int x0, input int y0, input int z0, output int xc, output int ys);
        int seq [16] = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13, 14};
        int tab [15] = '{0, 4500, 2092, 1029, 513, 256, 128, 64, 32, 16, 8, 4, 2, 1, 1};
        int x, y, z, nx, ny, d;
        x = w16(x0);
        y = w16(y0);
        z = w16(z0);
        for (int k = 0; k < 16; k++) begin
            d  = (z < 0) ? -1 : 1;
            nx = w16(x + d * (y >>> seq[k]));
            ny = w16(y + d * (x >>> seq[k]));
            z  = w16(z - d * tab[seq[k]]);
            x  = nx;
            y  = ny;
        end
        xc = x;
        ys = y;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input int a, input int b, input int c, output int rc, output int rs, output int lat);
        bus.iX     = 16'(a);
        bus.iY     = 16'(b);
        bus.iZ     = 16'(c);
        bus.iValid = 1'b1;
        tick();
        bus.iValid = 1'b0;
        lat = 0;
        while (!bus.oValid && lat < 40) begin
            tick();
            lat++;
        end
        rc = int'(bus.oCosh);
        rs = int'(bus.oSinh);
    endtask

    task automatic release_out();
        bus.oReady = 1'b1;
        tick();
        bus.oReady = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.iValid = 1'b0;
        bus.oReady = 1'b0;
        bus.iX = '0;
        bus.iY = '0;
        bus.iZ = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (bus.oValid !== 1'b0) begin errors++; $display("FAIL reset_ovalid got=%b exp=0", bus.oValid); end
        checks++;
        if (bus.oCosh !== 16'sd0 || bus.oSinh !== 16'sd0) begin
            errors++; $display("FAIL reset_outputs got=%0d/%0d exp=0/0", bus.oCosh, bus.oSinh);
        end
        checks++;
        if (bus.iReady !== 1'b1) begin errors++; $display("FAIL reset_iready got=%b exp=1", bus.iReady); end
    endtask

    task automatic test_golden();
        int vx [3] = '{9892, 9892, 9892};
        int vz [3] = '{0, 4096, -4096};
        int ec [3] = '{8192, 9237, 9237};
        int es [3] = '{0, 4269, -4269};
        int rc, rs, lat, mc, ms;
        for (int i = 0; i < 3; i++) begin
            run_op(vx[i], 0, vz[i], rc, rs, lat);
            model(vx[i], 0, vz[i], mc, ms);
            checks++;
            if (lat !== 17) begin errors++; $display("FAIL golden%0d_latency got=%0d exp=17", i, lat); end
            checks++;
            if (iabs(rc - ec[i]) > 8 || iabs(rs - es[i]) > 8) begin
                errors++; $display("FAIL golden%0d_value got=%0d/%0d exp=%0d/%0d +-8", i, rc, rs, ec[i], es[i]);
            end
            checks++;
            if (rc !== mc || rs !== ms) begin
                errors++; $display("FAIL golden%0d_model got=%0d/%0d exp=%0d/%0d", i, rc, rs, mc, ms);
            end
            release_out();
        end
    endtask

    task automatic test_backpressure();
        int rc, rs, lat, bad;
        run_op(9892, 0, 4096, rc, rs, lat);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.oValid !== 1'b1 || int'(bus.oCosh) !== rc || int'(bus.oSinh) !== rs) bad++;
        end
        checks++;
        if (bad != 0 || lat !== 17) begin
            errors++; $display("FAIL hold_stable got=%0d unstable cycles, lat=%0d exp=0, 17", bad, lat);
        end
        release_out();
        checks++;
        if (bus.oValid !== 1'b0) begin errors++; $display("FAIL release_ovalid got=%b exp=0", bus.oValid); end
        checks++;
        if (bus.iReady !== 1'b1) begin errors++; $display("FAIL release_iready got=%b exp=1", bus.iReady); end
    endtask

    task automatic test_busy_ignore();
        int mc, ms, lat, busy;
        int a, c;
        a = 9892;
        c = -3000;
        bus.iX = 16'(a);
        bus.iY = 16'(0);
        bus.iZ = 16'(c);
        bus.iValid = 1'b1;
        tick();
        lat = 0;
        busy = 0;
        while (!bus.oValid && lat < 40) begin
            bus.iX = 16'($urandom);
            bus.iY = 16'($urandom);
            bus.iZ = 16'($urandom);
            if (bus.iReady !== 1'b0) busy++;
            tick();
            lat++;
        end
        bus.iValid = 1'b0;
        model(a, 0, c, mc, ms);
        checks++;
        if (busy != 0) begin errors++; $display("FAIL busy_iready got=%0d ready cycles exp=0", busy); end
        checks++;
        if (lat !== 17 || int'(bus.oCosh) !== mc || int'(bus.oSinh) !== ms) begin
            errors++; $display("FAIL busy_result got=%0d/%0d lat=%0d exp=%0d/%0d lat=17", bus.oCosh, bus.oSinh, lat, mc, ms);
        end
        release_out();
    endtask

    task automatic test_reset_midrun();
        int rc, rs, lat, mc, ms;
        bus.iX = 16'(9892);
        bus.iY = 16'(0);
        bus.iZ = 16'(4096);
        bus.iValid = 1'b1;
        tick();
        bus.iValid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.oValid !== 1'b0 || bus.oCosh !== 16'sd0 || bus.oSinh !== 16'sd0 || bus.iReady !== 1'b1) begin
            errors++; $display("FAIL midrun_reset got=v%b c%0d s%0d r%b exp=v0 c0 s0 r1", bus.oValid, bus.oCosh, bus.oSinh, bus.iReady);
        end
        run_op(9892, 0, -4096, rc, rs, lat);
        model(9892, 0, -4096, mc, ms);
        checks++;
        if (lat !== 17 || rc !== mc || rs !== ms) begin
            errors++; $display("FAIL midrun_after got=%0d/%0d lat=%0d exp=%0d/%0d lat=17", rc, rs, lat, mc, ms);
        end
        release_out();
    endtask

    task automatic test_random();
        int a, b, c, rc, rs, lat, mc, ms, hold;
        for (int n = 0; n < 20; n++) begin
            a = w16(int'($urandom));
            b = w16(int'($urandom));
            c = w16(int'($urandom));
            if (n < 10) begin
                a = $urandom_range(12000, 8000);
                b = $urandom_range(2000, 0) - 1000;
                c = $urandom_range(8000, 0) - 4000;
            end
            run_op(a, b, c, rc, rs, lat);
            model(a, b, c, mc, ms);
            checks++;
            if (lat !== 17 || rc !== mc || rs !== ms) begin
                errors++; $display("FAIL random%0d got=%0d/%0d lat=%0d exp=%0d/%0d lat=17", n, rc, rs, lat, mc, ms);
            end
            hold = $urandom_range(3, 0);
            for (int i = 0; i < hold; i++) tick();
            release_out();
        end
    endtask

    task automatic test_back_to_back();
        int first_t, prev_t, cyc, got, mc, ms, bad_gap, bad_val;
        int ops [4][3] = '{'{9892, 0, 2048}, '{9892, 100, -2048}, '{8000, -500, 6000}, '{10000, 300, -7000}};
        int q [$];
        bus.oReady = 1'b1;
        cyc = 0;
        got = 0;
        prev_t = -100;
        first_t = 0;
        bad_gap = 0;
        bad_val = 0;
        while (got < 4 && cyc < 200) begin
            if (bus.oValid) begin
                model(ops[q[0]][0], ops[q[0]][1], ops[q[0]][2], mc, ms);
                if (int'(bus.oCosh) !== mc || int'(bus.oSinh) !== ms) bad_val++;
                if (got > 0 && cyc - prev_t < 18) bad_gap++;
                prev_t = cyc;
                void'(q.pop_front());
                got++;
            end
            bus.iValid = 1'b0;
            if (bus.iReady && q.size() == 0 && got + q.size() < 4) begin
                q.push_back(got);
                bus.iX = 16'(ops[got][0]);
                bus.iY = 16'(ops[got][1]);
                bus.iZ = 16'(ops[got][2]);
                bus.iValid = 1'b1;
            end
            tick();
            cyc++;
        end
        bus.iValid = 1'b0;
        bus.oReady = 1'b0;
        first_t = got;
        checks++;
        if (first_t !== 4) begin errors++; $display("FAIL b2b_count got=%0d exp=4", first_t); end
        checks++;
        if (bad_val != 0) begin errors++; $display("FAIL b2b_values got=%0d wrong exp=0", bad_val); end
        checks++;
        if (bad_gap != 0) begin errors++; $display("FAIL b2b_throughput got=%0d short gaps exp=0", bad_gap); end
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_golden();
        test_backpressure();
        test_busy_ignore();
        test_reset_midrun();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
